bank_refresh_scheduler: RTL
===========================

Name: bank_refresh_scheduler

Overview:
Sequences refresh across the gain-cell DRAM banks. It replaces the free-running refresh counter and the refresh-address counter with a single FSM. A refresh round starts every REF_INTERVAL cycles and walks banks 0..N_BANKS-1 in order. Each bank refresh is deferred while user traffic targets that bank, up to MAX_DEFER cycles; after that the bank is blocked and the refresh is forced. The block sits in the controller between the user enable decoders and the per-bank refresh shift registers.

Parameters:
N_BANKS, 8, number of banks; must be a power of two; pointer width is log2(N_BANKS).
REF_INTERVAL, 4055, idle cycles between the end of one refresh round and the start of the next.
MAX_DEFER, 16, maximum cycles a pending bank refresh yields to user access.
DONE_TIMEOUT, 256, maximum cycles to wait for a bank's ref_done rising edge.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
bank_busy  in  N_BANKS  per-bank user access this cycle (OR of write/read enable decodes).
ref_done  in  N_BANKS  per-bank refresh-complete level from the shift registers.
start_SR  out  N_BANKS  one-hot single-cycle pulse that starts a bank refresh.
ref_en_o  out  N_BANKS  one-hot level, high while the bank is being refreshed.
bank_block  out  N_BANKS  one-hot: the user must not access this bank.
ref_bank  out  log2(N_BANKS)  current bank pointer.
refreshing  out  1  high while a round is in progress (any state except IDLE).
cycle_done  out  1  single-cycle pulse when the last bank of a round finishes.
err_timeout  out  1  sticky; set on a done timeout, cleared only by rst.
err_bank  out  log2(N_BANKS)  bank of the most recent timeout.

Behaviour:
- States: IDLE, PEND, START, WAIT_DONE, NEXT. Outputs are Moore, decoded from the registered state, pointer and flags.
- Reset (rst high at a clk edge):
  - state=IDLE; int_cnt, defer_cnt, wait_cnt, ptr all 0; force=0.
  - All outputs 0, including err_timeout and err_bank.
  - Reset mid-round aborts the round immediately; ref_en_o and bank_block drop on the next cycle.
- IDLE:
  - int_cnt increments each cycle.
  - When int_cnt==REF_INTERVAL-1: go to PEND, clear int_cnt. The first PEND therefore occurs REF_INTERVAL cycles after rst deasserts.
- PEND:
  - If bank_busy[ptr]==0 or force==1: go to START.
  - Otherwise defer_cnt++. When defer_cnt reaches MAX_DEFER-1 while still busy, set force=1 and stay in PEND one more cycle. START follows on the next cycle.
  - bank_block[ptr]=force.
- START (exactly 1 cycle): start_SR[ptr]=1, ref_en_o[ptr]=1, bank_block[ptr]=1. Then go to WAIT_DONE with wait_cnt=0.
- WAIT_DONE:
  - ref_en_o[ptr]=1 and bank_block[ptr]=1.
  - A rising edge on ref_done[ptr] (registered previous value 0, current 1) moves to NEXT. ref_done of other banks is ignored.
  - A ref_done[ptr] that is already high on entry does not count; a fresh edge is required.
  - If wait_cnt==DONE_TIMEOUT-1 with no edge: err_timeout=1, err_bank=ptr, go to NEXT.
- NEXT (1 cycle): clear defer_cnt and force. Outputs are deasserted (ref_en_o=0, bank_block=0).
  - If ptr==N_BANKS-1: cycle_done=1, ptr wraps to 0, go to IDLE.
  - Else ptr++ and go to PEND.
- The interval counter is held at 0 from PEND through NEXT, so the interval is measured from the end of each round.
- At most one bit of start_SR, ref_en_o or bank_block is set in any cycle, and it is always bit ptr.
- A bank_busy change during START or WAIT_DONE has no effect; the user side must honour bank_block.
- Counter widths are clog2 of the respective parameter. No counter wraps silently; each is compared against its terminal value only.

Test Plan:
(Parameters for all scenarios: REF_INTERVAL=20, MAX_DEFER=4, DONE_TIMEOUT=10.)
- Reset, bank_busy=0, ref_done pulses 3 cycles after each start_SR → start_SR[0] at cycle 21 after reset, then banks 1..7 in order. cycle_done pulses once after bank 7; the next start_SR[0] occurs 20+1 cycles after the IDLE re-entry.
- bank_busy[2]=1 for 2 cycles at bank 2's PEND → start_SR[2] is delayed exactly 2 cycles; bank_block[2] is 0 during PEND.
- bank_busy[3] held high → bank_block[3] rises after 4 PEND cycles; start_SR[3] follows one cycle later; ref_en_o[3] stays high until the ref_done[3] edge.
- ref_done[5] never rises → after 10 WAIT_DONE cycles err_timeout=1 and err_bank=5; the round continues with bank 6; err_timeout stays set through later rounds.
- ref_done[4] held high before bank 4 starts, plus a ref_done[1] pulse during bank 4's WAIT_DONE → neither advances the FSM; only a 0→1 edge on ref_done[4] does.
- rst asserted for 1 cycle during bank 6's WAIT_DONE → the next cycle shows all outputs 0 and ptr=0; err flags are cleared; a new round starts 20 cycles later at bank 0.

Source files
------------

// File: rtl/bank_refresh_scheduler_if.sv
// Bundle between the user enable decoders, the refresh scheduler and the
// per-bank refresh shift registers.
interface bank_refresh_scheduler_if #(
  parameter int unsigned N_BANKS = 8
);
  localparam int unsigned PTR_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

  logic [N_BANKS-1:0] bank_busy;
  logic [N_BANKS-1:0] ref_done;
  logic [N_BANKS-1:0] start_SR;
  logic [N_BANKS-1:0] ref_en_o;
  logic [N_BANKS-1:0] bank_block;
  logic [PTR_W-1:0]   ref_bank;
  logic               refreshing;
  logic               cycle_done;
  logic               err_timeout;
  logic [PTR_W-1:0]   err_bank;

  modport master (
    input  bank_busy, ref_done,
    output start_SR, ref_en_o, bank_block, ref_bank,
           refreshing, cycle_done, err_timeout, err_bank
  );

  modport slave (
    output bank_busy, ref_done,
    input  start_SR, ref_en_o, bank_block, ref_bank,
           refreshing, cycle_done, err_timeout, err_bank
  );
endinterface

// File: rtl/bank_refresh_scheduler.sv
// Single-FSM refresh sequencer: periodic rounds over all banks, deferring each
// bank's refresh for user traffic up to a limit, with a done-edge timeout.
module bank_refresh_scheduler #(
  parameter int unsigned N_BANKS      = 8,
  parameter int unsigned REF_INTERVAL = 4055,
  parameter int unsigned MAX_DEFER    = 16,
  parameter int unsigned DONE_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  bank_refresh_scheduler_if.master bus
);
  localparam int unsigned PTR_W = (N_BANKS > 1)      ? $clog2(N_BANKS)      : 1;
  localparam int unsigned INT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int unsigned DEF_W = (MAX_DEFER > 1)    ? $clog2(MAX_DEFER)    : 1;
  localparam int unsigned WT_W  = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, PEND, START, WAIT_DONE, NEXT} state_e;

  state_e             state_q, state_d;
  logic [INT_W-1:0]   int_cnt_q, int_cnt_d;
  logic [DEF_W-1:0]   defer_cnt_q, defer_cnt_d;
  logic [WT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               force_q, force_d;
  logic               err_timeout_q, err_timeout_d;
  logic [PTR_W-1:0]   err_bank_q, err_bank_d;
  logic [N_BANKS-1:0] ref_done_q;
  logic               done_edge;
  logic [N_BANKS-1:0] ptr_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      int_cnt_q     <= '0;
      defer_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      ptr_q         <= '0;
      force_q       <= 1'b0;
      err_timeout_q <= 1'b0;
      err_bank_q    <= '0;
      ref_done_q    <= '0;
    end else begin
      state_q       <= state_d;
      int_cnt_q     <= int_cnt_d;
      defer_cnt_q   <= defer_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      ptr_q         <= ptr_d;
      force_q       <= force_d;
      err_timeout_q <= err_timeout_d;
      err_bank_q    <= err_bank_d;
      ref_done_q    <= bus.ref_done;
    end
  end

  // Only a fresh 0->1 transition on the selected bank counts as completion.
  assign done_edge = bus.ref_done[ptr_q] & ~ref_done_q[ptr_q];

  always_comb begin
    state_d       = state_q;
    int_cnt_d     = int_cnt_q;
    defer_cnt_d   = defer_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    ptr_d         = ptr_q;
    force_d       = force_q;
    err_timeout_d = err_timeout_q;
    err_bank_d    = err_bank_q;
    case (state_q)
      IDLE: begin
        if (int_cnt_q == INT_W'(REF_INTERVAL - 1)) begin
          int_cnt_d = '0;
          state_d   = PEND;
        end else begin
          int_cnt_d = int_cnt_q + INT_W'(1);
        end
      end
      PEND: begin
        if (!bus.bank_busy[ptr_q] || force_q) begin
          state_d = START;
        end else if (defer_cnt_q == DEF_W'(MAX_DEFER - 1)) begin
          force_d = 1'b1;
        end else begin
          defer_cnt_d = defer_cnt_q + DEF_W'(1);
        end
      end
      START: begin
        wait_cnt_d = '0;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_edge) begin
          state_d = NEXT;
        end else if (wait_cnt_q == WT_W'(DONE_TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          err_bank_d    = ptr_q;
          state_d       = NEXT;
        end else begin
          wait_cnt_d = wait_cnt_q + WT_W'(1);
        end
      end
      NEXT: begin
        defer_cnt_d = '0;
        force_d     = 1'b0;
        if (ptr_q == PTR_W'(N_BANKS - 1)) begin
          ptr_d   = '0;
          state_d = IDLE;
        end else begin
          ptr_d   = ptr_q + PTR_W'(1);
          state_d = PEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ptr_onehot = N_BANKS'(1) << ptr_q;

  always_comb begin
    bus.start_SR    = (state_q == START) ? ptr_onehot : '0;
    bus.ref_en_o    = (state_q == START || state_q == WAIT_DONE) ? ptr_onehot : '0;
    bus.bank_block  = (state_q == START || state_q == WAIT_DONE ||
                       (state_q == PEND && force_q)) ? ptr_onehot : '0;
    bus.ref_bank    = ptr_q;
    bus.refreshing  = (state_q != IDLE);
    bus.cycle_done  = (state_q == NEXT) && (ptr_q == PTR_W'(N_BANKS - 1));
    bus.err_timeout = err_timeout_q;
    bus.err_bank    = err_bank_q;
  end
endmodule
